alu_arbiter: RTL and testbench

Two-requester arbiter and issue sequencer that shares a single ALU between the main pipeline EX stage (requester 0) and an auxiliary requester such as a coprocessor or debug engine (requester 1). It accepts one operation per cycle over a valid/ready handshake and registers the winning operands into an issue stage that drives the ALU. It then captures the ALU result and flags and returns them, tagged by requester, as a one-cycle response pulse. It sits between the requesters and the ALU's operand/function inputs.

---
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-requester arbiter and issue sequencer for a shared ALU.
//             Requester 0 (pipeline EX) and requester 1 (auxiliary) compete
//             over valid/ready. The winner's operands are registered into an
//             issue stage that drives the ALU. The ALU result and flags are
//             captured one cycle later and returned as a one-cycle response
//             pulse tagged by requester. Latency is 2 cycles and throughput
//             is 1 op/cycle.
//  Options  : ALU_ARB_RR_EN  -- when defined, conflicts are resolved
//             round-robin using a 1-bit last-grant pointer. Otherwise
//             requester 0 has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  // requester 0 (main pipeline)
  input  logic          req0_vld,
  output logic          req0_rdy,
  input  logic [2:0]    req0_func,
  input  logic [DW-1:0] req0_src0,
  input  logic [DW-1:0] req0_src1,
  input  logic [3:0]    req0_shamt,
  // requester 1 (auxiliary)
  input  logic          req1_vld,
  output logic          req1_rdy,
  input  logic [2:0]    req1_func,
  input  logic [DW-1:0] req1_src0,
  input  logic [DW-1:0] req1_src1,
  input  logic [3:0]    req1_shamt,
  // ALU side
  output logic [2:0]    alu_func,
  output logic [DW-1:0] alu_src0,
  output logic [DW-1:0] alu_src1,
  output logic [3:0]    alu_shamt,
  input  logic [DW-1:0] alu_dst,
  input  logic          alu_ov,
  input  logic          alu_zr,
  input  logic          alu_neg,
  // responses
  output logic          rsp0_vld,
  output logic          rsp1_vld,
  output logic [DW-1:0] rsp_dst,
  output logic          rsp_ov,
  output logic          rsp_zr,
  output logic          rsp_neg,
  output logic          busy
);

  logic grant0;
  logic grant1;
  logic accept;

`ifdef ALU_ARB_RR_EN
  // Pointer holds the id of the last granted requester; the other one wins a
  // conflict. Resetting to 1 makes requester 0 win the first conflict.
  logic rr_ptr_q;
  logic rr_ptr_d;

  // Round-robin grant and pointer update
  always_comb begin
    grant0   = req0_vld & (~req1_vld | rr_ptr_q);
    grant1   = req1_vld & (~req0_vld | ~rr_ptr_q);
    rr_ptr_d = accept ? grant1 : rr_ptr_q;
  end

  // Last-grant pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b1;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority grant: requester 0 always wins a conflict
  always_comb begin
    grant0 = req0_vld;
    grant1 = req1_vld & ~req0_vld;
  end
`endif

  assign accept   = grant0 | grant1;
  assign req0_rdy = grant0;
  assign req1_rdy = grant1;

  // Issue stage registers
  logic          iss_vld_q,   iss_vld_d;
  logic          iss_id_q,    iss_id_d;
  logic [2:0]    iss_func_q,  iss_func_d;
  logic [DW-1:0] iss_src0_q,  iss_src0_d;
  logic [DW-1:0] iss_src1_q,  iss_src1_d;
  logic [3:0]    iss_shamt_q, iss_shamt_d;

  // Response stage registers
  logic          rsp0_vld_q,  rsp0_vld_d;
  logic          rsp1_vld_q,  rsp1_vld_d;
  logic [DW-1:0] rsp_dst_q,   rsp_dst_d;
  logic          rsp_ov_q,    rsp_ov_d;
  logic          rsp_zr_q,    rsp_zr_d;
  logic          rsp_neg_q,   rsp_neg_d;

  // Issue next-state: load the winner, otherwise park the ALU on ADD of zeros
  // so the operand buses do not toggle while idle.
  always_comb begin
    iss_vld_d   = accept;
    iss_id_d    = grant1;
    iss_func_d  = 3'd0;
    iss_src0_d  = '0;
    iss_src1_d  = '0;
    iss_shamt_d = 4'd0;
    if (grant0) begin
      iss_func_d  = req0_func;
      iss_src0_d  = req0_src0;
      iss_src1_d  = req0_src1;
      iss_shamt_d = req0_shamt;
    end else if (grant1) begin
      iss_func_d  = req1_func;
      iss_src0_d  = req1_src0;
      iss_src1_d  = req1_src1;
      iss_shamt_d = req1_shamt;
    end
  end

  // Response next-state: capture ALU output behind a valid issue, else hold
  always_comb begin
    rsp0_vld_d = iss_vld_q & ~iss_id_q;
    rsp1_vld_d = iss_vld_q &  iss_id_q;
    rsp_dst_d  = rsp_dst_q;
    rsp_ov_d   = rsp_ov_q;
    rsp_zr_d   = rsp_zr_q;
    rsp_neg_d  = rsp_neg_q;
    if (iss_vld_q) begin
      rsp_dst_d = alu_dst;
      rsp_ov_d  = alu_ov;
      rsp_zr_d  = alu_zr;
      rsp_neg_d = alu_neg;
    end
  end

  // Issue and response stage registers; reset discards in-flight ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q   <= 1'b0;
      iss_id_q    <= 1'b0;
      iss_func_q  <= 3'd0;
      iss_src0_q  <= '0;
      iss_src1_q  <= '0;
      iss_shamt_q <= 4'd0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp_dst_q   <= '0;
      rsp_ov_q    <= 1'b0;
      rsp_zr_q    <= 1'b0;
      rsp_neg_q   <= 1'b0;
    end else begin
      iss_vld_q   <= iss_vld_d;
      iss_id_q    <= iss_id_d;
      iss_func_q  <= iss_func_d;
      iss_src0_q  <= iss_src0_d;
      iss_src1_q  <= iss_src1_d;
      iss_shamt_q <= iss_shamt_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_ov_q    <= rsp_ov_d;
      rsp_zr_q    <= rsp_zr_d;
      rsp_neg_q   <= rsp_neg_d;
    end
  end

  assign alu_func  = iss_func_q;
  assign alu_src0  = iss_src0_q;
  assign alu_src1  = iss_src1_q;
  assign alu_shamt = iss_shamt_q;

  assign rsp0_vld  = rsp0_vld_q;
  assign rsp1_vld  = rsp1_vld_q;
  assign rsp_dst   = rsp_dst_q;
  assign rsp_ov    = rsp_ov_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_neg   = rsp_neg_q;

  assign busy = iss_vld_q | rsp0_vld_q | rsp1_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter with a small
//             16-bit signed saturating ALU stub on the ALU side.
//             Build with ALU_ARB_RR_EN defined to check round-robin mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DW = 17;
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_SLL = 3'd2;
  localparam logic [2:0] F_SRA = 3'd3;
  localparam logic [2:0] F_NOR = 3'd4;

  logic          clk;
  logic          rst_n;
  logic          req0_vld, req1_vld;
  logic          req0_rdy, req1_rdy;
  logic [2:0]    req0_func, req1_func;
  logic [DW-1:0] req0_src0, req0_src1, req1_src0, req1_src1;
  logic [3:0]    req0_shamt, req1_shamt;
  logic [2:0]    alu_func;
  logic [DW-1:0] alu_src0, alu_src1;
  logic [3:0]    alu_shamt;
  logic [DW-1:0] alu_dst;
  logic          alu_ov, alu_zr, alu_neg;
  logic          rsp0_vld, rsp1_vld;
  logic [DW-1:0] rsp_dst;
  logic          rsp_ov, rsp_zr, rsp_neg;
  logic          busy;

  int tests;
  int fails;

  alu_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_vld  (req0_vld),
    .req0_rdy  (req0_rdy),
    .req0_func (req0_func),
    .req0_src0 (req0_src0),
    .req0_src1 (req0_src1),
    .req0_shamt(req0_shamt),
    .req1_vld  (req1_vld),
    .req1_rdy  (req1_rdy),
    .req1_func (req1_func),
    .req1_src0 (req1_src0),
    .req1_src1 (req1_src1),
    .req1_shamt(req1_shamt),
    .alu_func  (alu_func),
    .alu_src0  (alu_src0),
    .alu_src1  (alu_src1),
    .alu_shamt (alu_shamt),
    .alu_dst   (alu_dst),
    .alu_ov    (alu_ov),
    .alu_zr    (alu_zr),
    .alu_neg   (alu_neg),
    .rsp0_vld  (rsp0_vld),
    .rsp1_vld  (rsp1_vld),
    .rsp_dst   (rsp_dst),
    .rsp_ov    (rsp_ov),
    .rsp_zr    (rsp_zr),
    .rsp_neg   (rsp_neg),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: 16-bit signed saturating arithmetic, result sign-extended to DW
  logic [16:0] alu_sum;
  logic [15:0] alu_res;
  logic        alu_sat;
  always_comb begin
    alu_sum = 17'd0;
    alu_res = 16'd0;
    alu_sat = 1'b0;
    case (alu_func)
      F_ADD, F_SUB: begin
        if (alu_func == F_ADD)
          alu_sum = {alu_src0[15], alu_src0[15:0]} + {alu_src1[15], alu_src1[15:0]};
        else
          alu_sum = {alu_src1[15], alu_src1[15:0]} - {alu_src0[15], alu_src0[15:0]};
        alu_sat = alu_sum[16] ^ alu_sum[15];
        if (alu_sat) alu_res = alu_sum[16] ? 16'h8000 : 16'h7FFF;
        else         alu_res = alu_sum[15:0];
      end
      F_SLL:   alu_res = alu_src1[15:0] << alu_shamt;
      F_SRA:   alu_res = 16'($signed(alu_src1[15:0]) >>> alu_shamt);
      F_NOR:   alu_res = ~(alu_src0[15:0] | alu_src1[15:0]);
      default: alu_res = 16'd0;
    endcase
    alu_dst = {alu_res[15], alu_res};
    alu_ov  = alu_sat;
    alu_zr  = (alu_res == 16'd0);
    alu_neg = alu_res[15];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [2:0] f, input logic [DW-1:0] s0,
                          input logic [DW-1:0] s1, input logic [3:0] sh);
    req0_vld = v; req0_func = f; req0_src0 = s0; req0_src1 = s1; req0_shamt = sh;
  endtask

  task automatic set_req1(input logic v, input logic [2:0] f, input logic [DW-1:0] s0,
                          input logic [DW-1:0] s1, input logic [3:0] sh);
    req1_vld = v; req1_func = f; req1_src0 = s0; req1_src1 = s1; req1_shamt = sh;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic exp_g1 [4];

  initial begin
    tests = 0;
    fails = 0;
`ifdef ALU_ARB_RR_EN
    exp_g1[0] = 1'b0; exp_g1[1] = 1'b1; exp_g1[2] = 1'b0; exp_g1[3] = 1'b1;
`else
    exp_g1[0] = 1'b0; exp_g1[1] = 1'b0; exp_g1[2] = 1'b0; exp_g1[3] = 1'b0;
`endif
    rst_n = 1'b0;
    set_req0(1'b0, 3'd0, '0, '0, 4'd0);
    set_req1(1'b0, 3'd0, '0, '0, 4'd0);

    // reset state
    #1;
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_rsp0_vld", 32'(rsp0_vld), 32'd0);
    chk("rst_rsp1_vld", 32'(rsp1_vld), 32'd0);
    chk("rst_rsp_dst",  32'(rsp_dst),  32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_alu_src1", 32'(alu_src1), 32'd0);
    chk("rst_flags",    32'({rsp_ov, rsp_zr, rsp_neg}), 32'd0);
    req1_vld = 1'b1;
    #1;
    chk("rst_rdy1_live", 32'(req1_rdy), 32'd1);
    req1_vld = 1'b0;
    cyc();
    cyc();
    chk("rst_hold_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // req0 only: saturating ADD
    set_req0(1'b1, F_ADD, 17'h00001, 17'h07FFF, 4'd0);
    #1;
    chk("t1_rdy0", 32'(req0_rdy), 32'd1);
    chk("t1_rdy1", 32'(req1_rdy), 32'd0);
    cyc();
    chk("t1_alu_src1", 32'(alu_src1), 32'h07FFF);
    chk("t1_busy",     32'(busy),     32'd1);
    req0_vld = 1'b0;
    cyc();
    chk("t1_rsp0_vld", 32'(rsp0_vld), 32'd1);
    chk("t1_rsp1_vld", 32'(rsp1_vld), 32'd0);
    chk("t1_rsp_dst",  32'(rsp_dst),  32'h07FFF);
    chk("t1_rsp_ov",   32'(rsp_ov),   32'd1);
    chk("t1_rsp_zr",   32'(rsp_zr),   32'd0);
    cyc();
    chk("t1_pulse_end", 32'(rsp0_vld), 32'd0);
    chk("t1_idle_busy", 32'(busy),     32'd0);

    // req1 only: SUB to zero
    set_req1(1'b1, F_SUB, 17'h00005, 17'h00005, 4'd0);
    #1;
    chk("t2_rdy1", 32'(req1_rdy), 32'd1);
    chk("t2_rdy0", 32'(req0_rdy), 32'd0);
    cyc();
    req1_vld = 1'b0;
    cyc();
    chk("t2_rsp1_vld", 32'(rsp1_vld), 32'd1);
    chk("t2_rsp0_vld", 32'(rsp0_vld), 32'd0);
    chk("t2_rsp_dst",  32'(rsp_dst),  32'd0);
    chk("t2_rsp_zr",   32'(rsp_zr),   32'd1);
    cyc();

    // both valid for 4 cycles: conflict resolution
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set_req0(1'b1, F_SLL, 17'h00000, 17'h00001, 4'd4);
        set_req1(1'b1, F_NOR, 17'h00000, 17'h00000, 4'd0);
        #1;
        chk($sformatf("t3_rdy0_%0d", i), 32'(req0_rdy), 32'(!exp_g1[i]));
        chk($sformatf("t3_rdy1_%0d", i), 32'(req1_rdy), 32'(exp_g1[i]));
      end else begin
        req0_vld = 1'b0;
        req1_vld = 1'b0;
      end
      if (i >= 2) begin
        chk($sformatf("t3_rsp0_%0d", i - 2), 32'(rsp0_vld), 32'(!exp_g1[i-2]));
        chk($sformatf("t3_rsp1_%0d", i - 2), 32'(rsp1_vld), 32'(exp_g1[i-2]));
        if (exp_g1[i-2])
          chk($sformatf("t3_dst1_%0d", i - 2), 32'(rsp_dst[15:0]), 32'h0FFFF);
        else
          chk($sformatf("t3_dst0_%0d", i - 2), 32'(rsp_dst), 32'h00010);
      end
      cyc();
    end
    cyc();

    // back-to-back req0: ADD then SRA
    set_req0(1'b1, F_ADD, 17'h00001, 17'h00002, 4'd0);
    #1;
    chk("t4_rdy0_a", 32'(req0_rdy), 32'd1);
    cyc();
    set_req0(1'b1, F_SRA, 17'h00000, 17'h08000, 4'd3);
    #1;
    chk("t4_rdy0_b", 32'(req0_rdy), 32'd1);
    cyc();
    req0_vld = 1'b0;
    chk("t4_rsp0_a", 32'(rsp0_vld), 32'd1);
    chk("t4_dst_a",  32'(rsp_dst),  32'h00003);
    chk("t4_neg_a",  32'(rsp_neg),  32'd0);
    cyc();
    chk("t4_rsp0_b", 32'(rsp0_vld),      32'd1);
    chk("t4_dst_b",  32'(rsp_dst[15:0]), 32'h0F000);
    chk("t4_neg_b",  32'(rsp_neg),       32'd1);
    cyc();

    // reset right after an accept discards the op
    set_req0(1'b1, F_ADD, 17'h00004, 17'h00004, 4'd0);
    cyc();
    req0_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",     32'(busy),     32'd0);
    chk("t5_alu_src0", 32'(alu_src0), 32'd0);
    chk("t5_rsp_dst",  32'(rsp_dst),  32'd0);
    chk("t5_rsp_neg",  32'(rsp_neg),  32'd0);
    cyc();
    chk("t5_no_rsp0",  32'(rsp0_vld), 32'd0);
    chk("t5_busy2",    32'(busy),     32'd0);
    rst_n = 1'b1;
    set_req0(1'b1, F_ADD, 17'h00002, 17'h00003, 4'd0);
    #1;
    chk("t5_rdy0", 32'(req0_rdy), 32'd1);
    cyc();
    req0_vld = 1'b0;
    chk("t5_early", 32'(rsp0_vld), 32'd0);
    cyc();
    chk("t5_rsp0", 32'(rsp0_vld), 32'd1);
    chk("t5_dst",  32'(rsp_dst),  32'h00005);
    cyc();

    // idle: ALU parked on zeros, response data held
    cyc();
    chk("t6_alu_func", 32'(alu_func), 32'd0);
    chk("t6_alu_src0", 32'(alu_src0), 32'd0);
    chk("t6_alu_src1", 32'(alu_src1), 32'd0);
    chk("t6_rsp_hold", 32'(rsp_dst),  32'h00005);
    chk("t6_no_rsp",   32'({rsp0_vld, rsp1_vld}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
